// File: rtl/delay_line.sv
// delay_line: tapped delay line of DEPTH {data,valid} stages with selectable output delay.
//   CLK    in  clock, rising edge
//   n_res  in  asynchronous active-low reset
//   EN     in  shift enable (0 holds all stages)
//   CLR    in  synchronous clear, priority over EN
//   D      in  data word
//   VIN    in  valid qualifier for D
//   TAP    in  output select, TAP=t gives delay t+1 (clamped to DEPTH)
//   Q      out data from selected stage
//   VOUT   out valid bit from selected stage
//   PRIMED out high once DEPTH enabled shifts since last reset/clear
module delay_line #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int TW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             n_res,
  input  logic             EN,
  input  logic             CLR,
  input  logic [WIDTH-1:0] D,
  input  logic             VIN,
  input  logic [TW-1:0]    TAP,
  output logic [WIDTH-1:0] Q,
  output logic             VOUT,
  output logic             PRIMED
);
  logic [WIDTH:0] r_stage [DEPTH];
  logic [CW-1:0]  r_fill;
  logic [TW-1:0]  w_sel;
  logic [WIDTH:0] w_word;
  always_ff @(posedge CLK or negedge n_res)
    if (!n_res) begin
      for (int k = 0; k < DEPTH; k++) r_stage[k] <= '0;
      r_fill <= '0;
    end else if (CLR) begin
      for (int k = 0; k < DEPTH; k++) r_stage[k] <= '0;
      r_fill <= '0;
    end else if (EN) begin
      r_stage[0] <= {D, VIN};
      for (int k = 1; k < DEPTH; k++) r_stage[k] <= r_stage[k-1];
      r_fill <= (r_fill == CW'(DEPTH)) ? r_fill : r_fill + CW'(1);
    end
  // taps past the last stage clamp to it; only reachable when DEPTH is not a power of two
  assign w_sel  = (TAP >= TW'(DEPTH - 1)) ? TW'(DEPTH - 1) : TAP;
  assign w_word = r_stage[w_sel];
  assign Q      = w_word[WIDTH:1];
  assign VOUT   = w_word[0];
  // decoded from the registered counter only, so TAP cannot disturb it
  assign PRIMED = (r_fill == CW'(DEPTH));
endmodule
